// File: rtl/calc_sequencer_pkg.sv
// calc_sequencer_pkg: shared FSM encoding, opcode bit positions and helpers for the calculator sequencer.
package calc_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, CAPTURE, RELEASE} state_t;
    localparam int NUM_BTN = 4;
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_DIV = 3;
    function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction
endpackage

// File: rtl/calc_sequencer_btn_debounce.sv
// btn_debounce: two-flop synchroniser plus stable-sample counter for one button bit.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk_pi,
    input  logic rst_n_pi,
    input  logic clk_en_pi,
    input  logic raw_pi,
    output logic level_po
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_pi};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // The level flips on the DEBOUNCE_TICKS-th consecutive differing sample.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (clk_en_pi) begin
            if (sync_q[1] == level_q) cnt_d = '0;
            else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                cnt_d   = '0;
                level_d = ~level_q;
            end else cnt_d = cnt_q + CW'(1);
        end
    end

    assign level_po = level_q;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: turns one debounced button press into one timed calculator operation
// and holds the operands, result and overflow for the display.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CALC_WAIT      = 2,
    parameter int DATA_W         = 4,
    parameter int RES_W          = 8
) (
    input  logic              clk_pi,
    input  logic              rst_n_pi,
    input  logic              clk_en_pi,
    input  logic [3:0]        btn_pi,
    input  logic [DATA_W-1:0] data1_pi,
    input  logic [DATA_W-1:0] data2_pi,
    output logic [DATA_W-1:0] calc_data1_po,
    output logic [DATA_W-1:0] calc_data2_po,
    output logic [3:0]        calc_op_po,
    input  logic [RES_W-1:0]  calc_result_pi,
    input  logic              calc_ovflw_pi,
    output logic [RES_W-1:0]  result_po,
    output logic              ovflw_po,
    output logic [15:0]       display_po,
    output logic              busy_po,
    output logic              done_po,
    output logic              err_po
);
    localparam int WC = (CALC_WAIT > 1) ? $clog2(CALC_WAIT) : 1;

    logic [NUM_BTN-1:0] btn_db, btn_prev_q;
    state_t             state_q, state_d;
    logic [WC-1:0]      wait_q, wait_d;
    logic [DATA_W-1:0]  data1_q, data1_d, data2_q, data2_d;
    logic [3:0]         op_q, op_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               ovflw_q, ovflw_d, err_q, err_d, press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
            .clk_pi(clk_pi), .rst_n_pi(rst_n_pi), .clk_en_pi(clk_en_pi),
            .raw_pi(btn_pi[i]), .level_po(btn_db[i])
        );
    end

    assign press = (btn_prev_q == '0) && (btn_db != '0);

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press) state_d = is_onehot(btn_db) ? EXEC : RELEASE;
            EXEC:    if (wait_q == '0) state_d = CAPTURE;
            CAPTURE: state_d = RELEASE;
            RELEASE: if (btn_db == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_po = (state_q == EXEC) || (state_q == CAPTURE);
        done_po = (state_q == CAPTURE);
    end

    // Operands and opcode only move on a valid press; result only on capture.
    always_comb begin
        data1_d  = data1_q;
        data2_d  = data2_q;
        op_d     = op_q;
        result_d = result_q;
        ovflw_d  = ovflw_q;
        err_d    = err_q;
        wait_d   = (state_q == EXEC && wait_q != '0) ? wait_q - WC'(1) : wait_q;
        if (state_q == IDLE && press) begin
            if (is_onehot(btn_db)) begin
                data1_d = data1_pi;
                data2_d = data2_pi;
                op_d    = btn_db;
                err_d   = 1'b0;
                wait_d  = WC'(CALC_WAIT - 1);
            end else err_d = 1'b1;
        end
        if (state_q == CAPTURE) begin
            result_d = calc_result_pi;
            ovflw_d  = calc_ovflw_pi;
            op_d     = '0;
        end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            btn_prev_q <= '0;
            wait_q     <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            op_q       <= '0;
            result_q   <= '0;
            ovflw_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            btn_prev_q <= btn_db;
            wait_q     <= wait_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            op_q       <= op_d;
            result_q   <= result_d;
            ovflw_q    <= ovflw_d;
            err_q      <= err_d;
        end
    end

    assign calc_data1_po = data1_q;
    assign calc_data2_po = data2_q;
    assign calc_op_po    = op_q;
    assign result_po     = result_q;
    assign ovflw_po      = ovflw_q;
    assign err_po        = err_q;
    assign display_po    = {data1_q, data2_q, result_q};
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and randomized checks of calc_sequencer against a behavioural model.
module tb_calc_sequencer;
    localparam int DT = 4;
    localparam int CW = 2;

    logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1;
    logic [3:0]  btn = '0, d1 = '0, d2 = '0;
    logic [3:0]  cd1, cd2, cop;
    logic [7:0]  cres, res;
    logic        covf, ovf, busy, done, err;
    logic [15:0] disp;
    int          total = 0, bad = 0;
    int          done_n = 0, op_n = 0, busy_n = 0;

    calc_sequencer #(.DEBOUNCE_TICKS(DT), .CALC_WAIT(CW), .DATA_W(4), .RES_W(8)) dut (
        .clk_pi(clk), .rst_n_pi(rst_n), .clk_en_pi(clk_en), .btn_pi(btn),
        .data1_pi(d1), .data2_pi(d2), .calc_data1_po(cd1), .calc_data2_po(cd2),
        .calc_op_po(cop), .calc_result_pi(cres), .calc_ovflw_pi(covf),
        .result_po(res), .ovflw_po(ovf), .display_po(disp), .busy_po(busy),
        .done_po(done), .err_po(err)
    );

    always #5 clk = ~clk;

    // Calculator behaviour: {overflow, result} for a one-hot opcode.
    function automatic logic [8:0] calc(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            4'b0001: return {s > 5'd15, 3'b0, s};
            4'b0010: return {a < b, 8'({4'b0, a} - {4'b0, b})};
            4'b0100: return {1'b0, 8'({4'b0, a} * {4'b0, b})};
            4'b1000: return (b == 0) ? 9'h1FF : {1'b0, 4'b0, a / b};
            default: return '0;
        endcase
    endfunction

    assign {covf, cres} = calc(cop, cd1, cd2);

    always @(negedge clk) begin
        done_n += int'(done);
        op_n   += int'(cop != 0);
        busy_n += int'(busy);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One press of button b with operands a/c; press-to-done latency is sync + debounce + 1 + CALC_WAIT.
    task automatic do_op(input logic [3:0] b, input logic [3:0] a, input logic [3:0] c,
                         input int hold, input bit change);
        int d0, o0, b0, cyc;
        logic [8:0] exp;
        d1 = a; d2 = c;
        d0 = done_n; o0 = op_n; b0 = busy_n;
        exp = calc(b, a, c);
        btn = b;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (change && busy) begin d1 = ~a; d2 = ~c; end
        end
        chk("latency", cyc, 2 + DT + 1 + CW);
        wait_n(hold);
        btn = '0;
        wait_n(2 + DT + 3);
        chk("done_pulses", done_n - d0, 1);
        chk("op_cycles", op_n - o0, CW + 1);
        chk("busy_cycles", busy_n - b0, CW + 1);
        chk("result", res, exp[7:0]);
        chk("ovflw", ovf, exp[8]);
        chk("display", disp, {a, c, exp[7:0]});
        chk("err_clear", err, 0);
        chk("idle_op", cop, 0);
        d1 = a; d2 = c;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, o0;
        logic [7:0] r0;
        btn = 4'b0001;
        wait_n(10);
        chk("rst_display", disp, 16'h0000);
        chk("rst_op", cop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ovf", ovf, 0);
        btn = '0;
        rst_n = 1'b1;
        wait_n(10);
        chk("idle_display", disp, 16'h0000);
        chk("idle_busy", busy, 0);

        do_op(4'b0001, 4'h3, 4'h5, 10, 1'b0);
        chk("single_display", disp, 16'h3508);

        for (int i = 0; i < 10; i++)
            do_op(4'(1 << $urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                  int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)));

        // Bounce then settle on button 1: one operation.
        d1 = 4'h9; d2 = 4'h4; d0 = done_n;
        btn = 4'b0010; wait_n(1); btn = 4'b0000; wait_n(1); btn = 4'b0010; wait_n(1);
        wait_n(15); btn = '0; wait_n(12);
        chk("bounce_one_op", done_n - d0, 1);
        chk("bounce_result", res, 8'h05);
        // Toggles only: never stable long enough.
        d0 = done_n; o0 = op_n;
        for (int i = 0; i < 4; i++) begin btn = 4'b0010; wait_n(1); btn = 4'b0000; wait_n(1); end
        btn = 4'b0010; wait_n(3); btn = '0; wait_n(12);
        chk("toggle_no_op", done_n - d0, 0);
        chk("toggle_no_opcode", op_n - o0, 0);
        // No sample tick: level never changes.
        clk_en = 1'b0; btn = 4'b0001; wait_n(20); btn = '0; wait_n(4); clk_en = 1'b1; wait_n(10);
        chk("no_clken_no_op", done_n - d0, 0);

        // Multi-button press.
        r0 = res; o0 = op_n;
        btn = 4'b0101; wait_n(15);
        chk("multi_err", err, 1);
        chk("multi_no_op", op_n - o0, 0);
        chk("multi_result", res, r0);
        chk("multi_busy", busy, 0);
        btn = '0; wait_n(12);
        chk("multi_err_held", err, 1);
        do_op(4'b0100, 4'h7, 4'h3, 10, 1'b0);

        // Long hold with operand change, then re-press.
        do_op(4'b0100, 4'hA, 4'h6, 50, 1'b1);
        do_op(4'b0100, 4'h2, 4'hB, 5, 1'b0);

        do_op(4'b0001, 4'hF, 4'hF, 5, 1'b0);
        chk("ovf_held", ovf, 1);

        // Abort with reset during EXEC.
        d0 = done_n; btn = 4'b0010;
        for (int i = 0; i < 50 && !busy; i++) wait_n(1);
        chk("abort_reached_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_op", cop, 0);
        chk("abort_display", disp, 16'h0000);
        chk("abort_ovf", ovf, 0);
        wait_n(5);
        chk("abort_no_done", done_n - d0, 0);
        btn = '0; rst_n = 1'b1; wait_n(10);
        do_op(4'b1000, 4'hE, 4'h3, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Sequences the 4-bit calculator datapath from the board buttons. Debounces BTN[3:0] and turns one clean press into one operation: it latches the operands, drives the one-hot opcode for a fixed settle window, then captures result and overflow into holding registers. Sits in top between the switches/buttons, the calculator and the display value; clkdiv's clk_en supplies the debounce sample tick.

Parameters:
DEBOUNCE_TICKS, 4, consecutive identical samples (on clk_en_pi) required before a button's debounced level changes
CALC_WAIT, 2, clk_pi cycles the opcode is held before result capture (min 1)
DATA_W, 4, operand width
RES_W, 8, result width

Ports:
clk_pi  in  1  system clock
rst_n_pi  in  1  asynchronous active-low reset
clk_en_pi  in  1  debounce sample tick (one clk_pi cycle wide)
btn_pi  in  4  raw buttons, one per operation
data1_pi  in  DATA_W  operand 1 switches
data2_pi  in  DATA_W  operand 2 switches
calc_data1_po  out  DATA_W  latched operand 1 to calculator
calc_data2_po  out  DATA_W  latched operand 2 to calculator
calc_op_po  out  4  one-hot opcode to calculator, 0 = no operation
calc_result_pi  in  RES_W  calculator result
calc_ovflw_pi  in  1  calculator overflow
result_po  out  RES_W  held result
ovflw_po  out  1  held overflow
display_po  out  16  {calc_data1_po, calc_data2_po, result_po}
busy_po  out  1  high from operand latch through capture
done_po  out  1  one-cycle pulse on capture
err_po  out  1  multi-button press flag

Behaviour:
- Reset: every register 0; state IDLE; all outputs 0 (display_po = 16'h0000). Assertion mid-operation aborts immediately; no capture, no done_po.
- Debounce: btn_pi double-flopped. Per bit, on each clk_en_pi: sample != debounced level -> counter++, else counter cleared; counter reaching DEBOUNCE_TICKS flips the level and clears the counter. No clk_en_pi -> no change. clk_en_pi tied high is legal.
- Press event: debounced vector goes from 4'b0000 to nonzero, evaluated every clk_pi cycle.
- FSM states: IDLE, EXEC, CAPTURE, RELEASE.
- IDLE: calc_op_po = 0. Press event with exactly one bit set -> latch data1_pi/data2_pi into calc_data1_po/calc_data2_po, set calc_op_po = debounced vector, clear err_po, load wait counter with CALC_WAIT-1, go to EXEC. Press event with more than one bit set -> err_po = 1, operands, op and result unchanged, go to RELEASE.
- EXEC: busy_po = 1, calc_op_po held. Counter decrements each cycle; at 0 go to CAPTURE. Switch changes during EXEC are ignored.
- CAPTURE (one cycle): result_po <= calc_result_pi, ovflw_po <= calc_ovflw_pi, done_po = 1, busy_po = 1. Then calc_op_po <= 0 and go to RELEASE.
- RELEASE: wait until the debounced vector is 0, then go to IDLE. Extra buttons pressed while waiting are ignored. A held button never retriggers.
- result_po/ovflw_po/operands persist until the next valid capture or reset. err_po persists until the next valid press.
- Latency: valid press event to done_po = CALC_WAIT+1 clk_pi cycles. busy_po is high for CALC_WAIT+1 cycles.
- Debounced press and release in the same tick cannot occur; any bit rising while others are already high, outside IDLE, is ignored.

Decomposition:
- Shared package: state encoding constants (IDLE, EXEC, CAPTURE, RELEASE) and the opcode bit positions (ADD, SUB, MUL, etc., matching calculator op_pi).
- One sub-module: btn_debounce, a per-bit synchroniser plus counter (parameter DEBOUNCE_TICKS, ports clk_pi, rst_n_pi, clk_en_pi, raw_pi, level_po), instantiated 4x via generate.

Test Plan:
- Reset: hold rst_n_pi=0 with btn_pi=4'b0001 -> all outputs 0. Release reset with buttons low -> state IDLE, display_po=16'h0000.
- Single op: data1=4'h3, data2=4'h5, clk_en_pi tied high, press btn_pi=4'b0001 for 10 cycles; calculator model returns 8'h08 -> calc_op_po=4'b0001 for exactly CALC_WAIT+1 cycles, done_po one pulse, result_po=8'h08, display_po=16'h3508.
- Bounce: toggle btn_pi[1] every tick for 3 ticks, then hold 1 for 4 ticks -> exactly one operation. Toggles alone (fewer than 4 stable samples) -> no operation.
- Multi-button: press 4'b0101 together -> err_po=1, calc_op_po stays 0, result_po unchanged. Release, then press 4'b0100 -> err_po cleared, operation runs.
- Hold/operand change: hold btn_pi[2] for 50 cycles and change data1 during EXEC -> single done_po, operands are the values at the press. Release and re-press -> second operation.
- Overflow/abort: model returns ovflw=1 -> ovflw_po=1 held. Start a new op and pull rst_n_pi low during EXEC -> outputs 0 immediately, no done_po.
